// File: rtl/qed_instruction_buffer_pkg.sv
// Shared constants and types for the QED instruction buffer (package qed_pkg).
package qed_pkg;

  localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
  localparam logic [6:0]  OPC_STORE    = 7'b0100011;
  localparam logic [6:0]  OPC_ALUREG   = 7'b0110011;
  localparam logic [6:0]  OPC_ALUIMM   = 7'b0010011;
  localparam logic [2:0]  FUNCT3_W     = 3'b010;
  localparam logic [31:0] NOP_INSN_DEF = 32'h00000013;

  typedef enum logic {ST_ORIG, ST_DUP} state_t;

endpackage

// File: rtl/qed_instruction_buffer_fifo.sv
// Generic synchronous FIFO (module qed_fifo); storage is not reset, only pointers and count.
module qed_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/qed_instruction_buffer.sv
// QED instruction buffer: passes fetches through, records eligible ones and replays them as duplicates.
// Optional macro QED_AUTO_DUP_EN: a full FIFO in ORIG starts replay without exec_dup.
module qed_instruction_buffer
  import qed_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter int          PTR_W    = 4,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           exec_dup,
  input  logic [31:0]    ifu_instruction,
  input  logic           ifu_valid,
  output logic           ifu_ready,
  output logic [31:0]    ifu_qed_instruction,
  output logic           qed_valid,
  output logic           is_dup,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty,
  output logic           commit_done
);

  function automatic logic is_eligible(input logic [6:0] opc, input logic [2:0] f3);
    return ((opc == OPC_LOAD)  && (f3 == FUNCT3_W)) ||
           ((opc == OPC_STORE) && (f3 == FUNCT3_W)) ||
           (opc == OPC_ALUREG) || (opc == OPC_ALUIMM);
  endfunction

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic           push;
  logic           pop;
  logic           last_pop;
  logic           dup_req;
  logic [PTR_W:0] count_after_push;
  logic [31:0]    head;

  logic [31:0]    insn_p0;
  logic           vld_p0;
  logic           dup_p0;
  logic           done_p0;

  qed_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (ifu_instruction),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ORIG;
    else     state <= state_nxt;
  end

  // A push in the same cycle as exec_dup counts towards the replay.
  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        ST_ORIG: if (dup_req && (count_after_push != '0)) state_nxt = ST_DUP;
        ST_DUP:  if (last_pop) state_nxt = ST_ORIG;
        default: state_nxt = ST_ORIG;
      endcase
    end
  end

  always_comb begin
    ifu_ready        = (state == ST_ORIG) && !full;
    accept           = ifu_valid && ifu_ready && ena;
    push             = accept && is_eligible(ifu_instruction[6:0], ifu_instruction[14:12]);
    pop              = ena && (state == ST_DUP) && !empty;
    last_pop         = pop && (count == (PTR_W+1)'(1));
    count_after_push = count + (PTR_W+1)'(push);
`ifdef QED_AUTO_DUP_EN
    dup_req          = exec_dup || full;
`else
    dup_req          = exec_dup;
`endif
  end

  // Output stage: one register between accept/pop and the decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      insn_p0 <= NOP_INSN;
      vld_p0  <= 1'b0;
      dup_p0  <= 1'b0;
      done_p0 <= 1'b0;
    end else begin
      done_p0 <= last_pop;
      if (ena) begin
        if (state == ST_DUP) begin
          insn_p0 <= head;
          vld_p0  <= pop;
          dup_p0  <= pop;
        end else if (accept) begin
          insn_p0 <= ifu_instruction;
          vld_p0  <= 1'b1;
          dup_p0  <= 1'b0;
        end else begin
          insn_p0 <= NOP_INSN;
          vld_p0  <= 1'b0;
          dup_p0  <= 1'b0;
        end
      end
    end
  end

  assign ifu_qed_instruction = insn_p0;
  assign qed_valid           = vld_p0;
  assign is_dup              = dup_p0;
  assign commit_done         = done_p0;

endmodule

// File: tb/tb_qed_instruction_buffer.sv
// Directed bench for qed_instruction_buffer with a queue-based reference model checked every cycle.
module tb_qed_instruction_buffer;

  localparam int          DEPTH = 16;
  localparam int          PTR_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic           clk = 1'b0;
  logic           rst, ena, exec_dup, ifu_valid;
  logic [31:0]    ifu_instruction;
  logic           ifu_ready, qed_valid, is_dup, full, empty, commit_done;
  logic [31:0]    ifu_qed_instruction;
  logic [PTR_W:0] count;

  int checks = 0;
  int errors = 0;

  qed_instruction_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NOP_INSN(NOP)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ena                 (ena),
    .exec_dup            (exec_dup),
    .ifu_instruction     (ifu_instruction),
    .ifu_valid           (ifu_valid),
    .ifu_ready           (ifu_ready),
    .ifu_qed_instruction (ifu_qed_instruction),
    .qed_valid           (qed_valid),
    .is_dup              (is_dup),
    .count               (count),
    .full                (full),
    .empty               (empty),
    .commit_done         (commit_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of recorded words plus a replay flag.
  logic [31:0] q[$];
  bit          m_dup = 0;
  bit          model_live = 0;
  logic [31:0] e_insn = NOP;
  bit          e_vld = 0, e_isdup = 0, e_done = 0;

  function automatic bit elig(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h23: return w[14:12] == 3'd2;
      7'h33, 7'h13: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dup = 0; e_insn = NOP; e_vld = 0; e_isdup = 0; e_done = 0;
      model_live = 1;
    end else if (model_live) begin
      e_done = 0;
      if (ena) begin
        if (!m_dup) begin
          bit was_full;
          bit go;
          was_full = (q.size() == DEPTH);
          if (ifu_valid && !was_full) begin
            e_insn = ifu_instruction; e_vld = 1;
            if (elig(ifu_instruction)) q.push_back(ifu_instruction);
          end else begin
            e_insn = NOP; e_vld = 0;
          end
          e_isdup = 0;
          go = exec_dup;
`ifdef QED_AUTO_DUP_EN
          go = go || was_full;
`endif
          if (go && q.size() != 0) m_dup = 1;
        end else begin
          e_insn = q.pop_front(); e_vld = 1; e_isdup = 1;
          if (q.size() == 0) begin m_dup = 0; e_done = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("m_insn",   ifu_qed_instruction, e_insn);
      chk("m_valid",  32'(qed_valid),   32'(e_vld));
      chk("m_is_dup", 32'(is_dup),      32'(e_isdup));
      chk("m_commit", 32'(commit_done), 32'(e_done));
      chk("m_count",  32'(count),       32'(q.size()));
      chk("m_full",   32'(full),        32'(q.size() == DEPTH));
      chk("m_empty",  32'(empty),       32'(q.size() == 0));
      chk("m_ready",  32'(ifu_ready),   32'(!m_dup && q.size() < DEPTH));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    ifu_valid = v;
    ifu_instruction = w;
  endtask

  logic [31:0] w3 [3];
  logic [31:0] held;

  initial begin
    w3[0] = 32'h00500093; w3[1] = 32'h002081B3; w3[2] = 32'h0000A203;
    rst = 1; ena = 0; exec_dup = 0; drive(0, 32'h0);
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("rst_insn",  ifu_qed_instruction, 32'h00000013);
    chk("rst_valid", 32'(qed_valid), 0);
    chk("rst_ready", 32'(ifu_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);

    // Three eligible pushes, then replay.
    ena = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, w3[i]);
      cyc();
      chk("orig_insn", ifu_qed_instruction, w3[i]);
      chk("orig_dup",  32'(is_dup), 0);
    end
    chk("count3", 32'(count), 3);
    drive(0, 32'h0);
    exec_dup = 1;
    cyc();
    exec_dup = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dup_insn", ifu_qed_instruction, w3[i]);
      chk("dup_flag", 32'(is_dup), 1);
      chk("dup_commit", 32'(commit_done), (i == 2) ? 32'd1 : 32'd0);
    end
    cyc();
    chk("post_ready",  32'(ifu_ready), 1);
    chk("post_commit", 32'(commit_done), 0);

    // Non-eligible jal and sb pass through unrecorded.
    drive(1, 32'h0000006F);
    cyc();
    chk("jal_insn",  ifu_qed_instruction, 32'h0000006F);
    chk("jal_valid", 32'(qed_valid), 1);
    chk("jal_count", 32'(count), 0);
    drive(1, 32'h00100023);
    cyc();
    chk("sb_count", 32'(count), 0);

    // Fill the FIFO (pointers wrap past the earlier three entries).
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h00000093 | (32'(i) << 20));
      cyc();
    end
    chk("fill_count", 32'(count), 16);
    chk("fill_full",  32'(full), 1);
    chk("fill_ready", 32'(ifu_ready), 0);
    drive(1, 32'h00F00113);
    cyc();
    chk("held_insn",  ifu_qed_instruction, NOP);
    chk("held_valid", 32'(qed_valid), 0);
    drive(0, 32'h0);
`ifndef QED_AUTO_DUP_EN
    exec_dup = 1;
    cyc();
    exec_dup = 0;
`endif
    cyc();
    chk("pop0_insn", ifu_qed_instruction, 32'h00000093);
    chk("pop0_dup",  32'(is_dup), 1);

    // Stall in DUP: everything frozen.
    ena = 0;
    held = ifu_qed_instruction;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_insn",  ifu_qed_instruction, held);
      chk("stall_count", 32'(count), 15);
    end
    ena = 1;
    cyc();
    chk("resume_insn",  ifu_qed_instruction, 32'h00100093);
    chk("resume_count", 32'(count), 14);

    // Reset mid-replay.
    rst = 1;
    cyc();
    rst = 0;
    chk("mrst_count",  32'(count), 0);
    chk("mrst_dup",    32'(is_dup), 0);
    chk("mrst_commit", 32'(commit_done), 0);
    chk("mrst_ready",  32'(ifu_ready), 1);
    exec_dup = 1;
    cyc();
    exec_dup = 0;
    cyc();
    chk("ign_ready", 32'(ifu_ready), 1);
    chk("ign_dup",   32'(is_dup), 0);

    // Push and exec_dup in the same cycle: the pushed word is replayed.
    drive(1, 32'h00C00113);
    exec_dup = 1;
    cyc();
    drive(0, 32'h0);
    exec_dup = 0;
    chk("same_insn", ifu_qed_instruction, 32'h00C00113);
    chk("same_dup",  32'(is_dup), 0);
    cyc();
    chk("same_rinsn",  ifu_qed_instruction, 32'h00C00113);
    chk("same_rdup",   32'(is_dup), 1);
    chk("same_commit", 32'(commit_done), 1);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
